// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for data_path: fetch/decode/execute/mem/writeback plus PC ownership.
// Optional retired-instruction counter and `retired` port are enabled with CTRL_RETIRE_CNT_EN.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_rdata,
  input  logic        instr_ready,
  input  logic        jump_signal,
  output logic [7:0]  PC,
  output logic [15:0] instruct_reg,
  output logic        regdest,
  output logic        alusrc,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        branch,
  output logic        jump,
  output logic        halted,
`ifdef CTRL_RETIRE_CNT_EN
  output logic [15:0] retired,
`endif
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BEQ, C_JUMP, C_HALT
  } cls_t;

  function automatic cls_t classify(input logic [15:0] ir);
    cls_t c;
    if (ir == 16'hFFFF)            c = C_HALT;
    else if (!ir[15])              c = C_ALU_R;
    else if (!ir[14])              c = C_ALU_I;
    else if (ir[13:12] == 2'b00)   c = C_LOAD;
    else if (ir[13:12] == 2'b01)   c = C_STORE;
    else if (ir[13:12] == 2'b10)   c = C_BEQ;
    else                           c = C_JUMP;
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        regdest_q, regdest_d;
  logic        alusrc_q, alusrc_d;
  logic        memtoreg_q, memtoreg_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        branch_q, branch_d;
  logic        jump_q, jump_d;
  logic        halted_q, halted_d;

  cls_t        cls_cur;
  cls_t        cls_nxt;
  logic [7:0]  pc_seq;

  // State register: all control outputs are flops loaded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= 8'h00;
      ir_q       <= 16'h0000;
      regdest_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      regdest_q  <= regdest_d;
      alusrc_q   <= alusrc_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      jump_q     <= jump_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state and PC: every path back to FETCH carries the new PC on that same edge.
  always_comb begin
    cls_cur = classify(ir_q);
    pc_seq  = pc_q + 8'd1;
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH: begin
        if (instr_ready) begin
          ir_d    = instr_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (cls_cur == C_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        unique case (cls_cur)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BEQ: begin
            state_d = S_FETCH;
            pc_d    = jump_signal ? pc_seq + {{4{ir_q[3]}}, ir_q[3:0]} : pc_seq;
          end
          C_JUMP: begin
            state_d = S_FETCH;
            pc_d    = ir_q[7:0];
          end
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        if (cls_cur == C_LOAD) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_seq;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_seq;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs for the state being entered, decoded from the instruction that state will hold.
  always_comb begin
    cls_nxt    = classify(ir_d);
    regdest_d  = 1'b0;
    alusrc_d   = 1'b0;
    memtoreg_d = 1'b0;
    if (state_d != S_FETCH && state_d != S_HALT) begin
      regdest_d  = (cls_nxt == C_ALU_R);
      alusrc_d   = (cls_nxt == C_ALU_I) || (cls_nxt == C_LOAD) || (cls_nxt == C_STORE);
      memtoreg_d = (cls_nxt == C_LOAD);
    end
    regwrite_d = (state_d == S_WRITEBACK);
    memread_d  = (cls_nxt == C_LOAD) && (state_d == S_MEM || state_d == S_WRITEBACK);
    memwrite_d = (cls_nxt == C_STORE) && (state_d == S_MEM);
    branch_d   = (cls_nxt == C_BEQ) && (state_d == S_EXECUTE);
    jump_d     = (cls_nxt == C_JUMP) && (state_d == S_EXECUTE);
    halted_d   = (state_d == S_HALT);
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  // An instruction retires on the edge that returns to FETCH; HALT never does.
  always_comb begin
    retired_d = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= 16'h0000;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

  assign PC           = pc_q;
  assign instruct_reg = ir_q;
  assign regdest      = regdest_q;
  assign alusrc       = alusrc_q;
  assign memtoreg     = memtoreg_q;
  assign regwrite     = regwrite_q;
  assign memread      = memread_q;
  assign memwrite     = memwrite_q;
  assign branch       = branch_q;
  assign jump         = jump_q;
  assign halted       = halted_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level reference model expands each fetched
// instruction into its per-cycle output trace; a monitor compares the DUT against that trace.
module tb_control_sequencer;

  localparam int W = 49;  // {pc, ir, 9 flags, retired}
  localparam logic [8:0] F_REGDEST  = 9'h100;
  localparam logic [8:0] F_ALUSRC   = 9'h080;
  localparam logic [8:0] F_MEMTOREG = 9'h040;
  localparam logic [8:0] F_REGWRITE = 9'h020;
  localparam logic [8:0] F_MEMREAD  = 9'h010;
  localparam logic [8:0] F_MEMWRITE = 9'h008;
  localparam logic [8:0] F_BRANCH   = 9'h004;
  localparam logic [8:0] F_JUMP     = 9'h002;
  localparam logic [8:0] F_HALTED   = 9'h001;

  logic        clk;
  logic        reset;
  logic [15:0] instr_rdata;
  logic        instr_ready;
  logic        jump_signal;
  logic [7:0]  PC;
  logic [15:0] instruct_reg;
  logic        regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, halted;
  logic [2:0]  state_dbg;
  logic [15:0] act_retired;
`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
  assign act_retired = retired;
`else
  assign act_retired = 16'h0000;
`endif

  control_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr_rdata  (instr_rdata),
    .instr_ready  (instr_ready),
    .jump_signal  (jump_signal),
    .PC           (PC),
    .instruct_reg (instruct_reg),
    .regdest      (regdest),
    .alusrc       (alusrc),
    .memtoreg     (memtoreg),
    .regwrite     (regwrite),
    .memread      (memread),
    .memwrite     (memwrite),
    .branch       (branch),
    .jump         (jump),
    .halted       (halted),
`ifdef CTRL_RETIRE_CNT_EN
    .retired      (retired),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [15:0]  imem [256];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] plan_q [$];
  int           js_q [$];      // jump_signal to drive in the cycle producing a plan entry; 2 = random
  logic [7:0]   m_pc;
  logic [15:0]  m_ir;
  logic         m_halted;
  logic [15:0]  m_retired;
  int           n_vec;
  int           n_miss;

  function automatic logic [W-1:0] pack(input logic [7:0] pc, input logic [15:0] ir,
                                        input logic [8:0] fl, input logic [15:0] ret);
`ifndef CTRL_RETIRE_CNT_EN
    ret = 16'h0000;
`endif
    return {pc, ir, fl, ret};
  endfunction

  // Expand one instruction into the outputs seen after each of its remaining edges.
  task automatic build_plan(input logic [15:0] ir);
    logic [8:0]  steps [$];
    logic [8:0]  sel;
    logic [7:0]  nxt;
    logic [15:0] r0;
    int          js_ret;
    int          off;
    int          taken;
    r0     = m_retired;
    m_ir   = ir;
    nxt    = m_pc + 8'd1;
    js_ret = 2;
    if (ir == 16'hFFFF) begin
      plan_q.push_back(pack(m_pc, ir, 9'h000, r0));   js_q.push_back(2);
      plan_q.push_back(pack(m_pc, ir, F_HALTED, r0)); js_q.push_back(2);
      m_halted = 1'b1;
      return;
    end
    case (ir[15:12])
      4'hC: begin
        sel   = F_ALUSRC | F_MEMTOREG;
        steps = '{sel, sel, sel | F_MEMREAD, sel | F_MEMREAD | F_REGWRITE};
      end
      4'hD: begin
        sel   = F_ALUSRC;
        steps = '{sel, sel, sel | F_MEMWRITE};
      end
      4'hE: begin
        steps  = '{9'h000, F_BRANCH};
        taken  = $urandom_range(0, 1);
        off    = int'(ir[3:0]);
        if (off > 7) off = off - 16;
        if (taken != 0) nxt = 8'((int'(m_pc) + 1 + off) & 255);
        js_ret = taken;
      end
      4'hF: begin
        steps = '{9'h000, F_JUMP};
        nxt   = ir[7:0];
      end
      default: begin
        sel   = (ir[15] == 1'b0) ? F_REGDEST : F_ALUSRC;
        steps = '{sel, sel, sel | F_REGWRITE};
      end
    endcase
    foreach (steps[i]) begin
      plan_q.push_back(pack(m_pc, ir, steps[i], r0));
      js_q.push_back(2);
    end
    plan_q.push_back(pack(nxt, ir, 9'h000, r0 + 16'd1));
    js_q.push_back(js_ret);
    m_pc      = nxt;
    m_retired = r0 + 16'd1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input int rdy_pct);
    logic [W-1:0] e;
    int           js;
    reset       = rst;
    instr_ready = ($urandom_range(0, 99) < rdy_pct);
    instr_rdata = 16'($urandom);
    jump_signal = 1'($urandom);
    if (rst) begin
      plan_q.delete();
      js_q.delete();
      m_pc      = 8'h00;
      m_ir      = 16'h0000;
      m_halted  = 1'b0;
      m_retired = 16'h0000;
      e = pack(8'h00, 16'h0000, 9'h000, 16'h0000);
    end else begin
      if (plan_q.size() == 0 && !m_halted && instr_ready) begin
        instr_rdata = imem[m_pc];
        build_plan(imem[m_pc]);
      end
      if (plan_q.size() > 0) begin
        e  = plan_q.pop_front();
        js = js_q.pop_front();
        if (js != 2) jump_signal = js[0];
      end else if (m_halted) begin
        e = pack(m_pc, m_ir, F_HALTED, m_retired);
      end else begin
        e = pack(m_pc, m_ir, 9'h000, m_retired);
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_directed();
    foreach (imem[i]) imem[i] = 16'h0000;
    imem[8'h00] = 16'h0A56;  // R-type
    imem[8'h01] = 16'hC087;  // LOAD
    imem[8'h02] = 16'hD088;  // STORE
    imem[8'h03] = 16'h8321;  // I-type
    imem[8'h04] = 16'hF005;  // JUMP 5
    imem[8'h05] = 16'hE00D;  // BEQ -3 -> 3 or 6
    imem[8'h06] = 16'hF010;  // JUMP 0x10
    imem[8'h10] = 16'hF0FF;  // JUMP 0xFF
    imem[8'hFF] = 16'h0123;  // R-type, PC wraps to 0
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = pack(PC, instruct_reg,
                     {regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, halted},
                     act_retired);
        n_vec++;
        if (act_v !== exp_v) begin
          n_miss++;
          $display("FAIL outputs @%0t: got pc=%h ir=%h flags=%b ret=%h, expected pc=%h ir=%h flags=%b ret=%h",
                   $time, act_v[48:41], act_v[40:25], act_v[24:16], act_v[15:0],
                   exp_v[48:41], exp_v[40:25], exp_v[24:16], exp_v[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus and report ----------------
  initial begin
    n_vec       = 0;
    n_miss      = 0;
    reset       = 1'b1;
    instr_ready = 1'b0;
    instr_rdata = 16'h0000;
    jump_signal = 1'b0;
    m_pc        = 8'h00;
    m_ir        = 16'h0000;
    m_halted    = 1'b0;
    m_retired   = 16'h0000;

    load_directed();
    repeat (2) step(1'b1, 100);
    repeat (60) step(1'b0, 100);
    repeat (80) step(1'b0, 50);

    foreach (imem[i]) imem[i] = 16'h0000;
    imem[8'h00] = 16'h0A56;
    imem[8'h01] = 16'hFFFF;
    step(1'b1, 100);
    repeat (35) step(1'b0, 40);
    step(1'b1, 100);
    repeat (6) step(1'b0, 100);

    foreach (imem[i]) imem[i] = 16'($urandom);
    imem[$urandom_range(0, 255)] = 16'hFFFF;
    imem[$urandom_range(0, 255)] = 16'hFFFF;
    step(1'b1, 100);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 149) == 0, 70);
    end

    @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
